div_seq_sr: RTL

- Parametrised multi-cycle radix-2 restoring divider. Generational successor to the team's fixed-width unsigned FSM divider.
- Adds per-operation signed/unsigned mode, valid/ready handshakes on both sides, output back-pressure, and divide-by-zero/overflow flags.
- Sits beside the ALU datapath as a shared long-latency unit; one operation in flight at a time.

---
 rtl/div_pkg.sv | 31 +++
 rtl/div_sign_adj.sv | 25 ++
 rtl/div_seq_sr.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and constants for the sequential restoring
//               divider (div_seq_sr). Holds the FSM state encoding and the
//               width-independent bit patterns that the top slices down to
//               DATAWIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  // Widest DATAWIDTH the constant patterns below can serve.
  localparam int DIV_MAX_W = 64;

  // Quotient pattern reported on divide-by-zero (all ones), full width.
  localparam logic [DIV_MAX_W-1:0] DIV_ZERO_QUO = {DIV_MAX_W{1'b1}};

  // Most-negative two's-complement value at full width; the top shifts it
  // down so that only the MSB of a DATAWIDTH word remains set.
  localparam logic [DIV_MAX_W-1:0] DIV_SMIN = {1'b1, {(DIV_MAX_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    FIX  = 3'd2,
    ZERO = 3'd3,
    DONE = 3'd4
  } div_state_e;

endpackage
`default_nettype wire

// File: rtl/div_sign_adj.sv
`default_nettype none
// ============================================================================
// Module      : div_sign_adj
// Description : Combinational conditional two's-complement negation. With
//               negate = sign bit it yields the magnitude of a signed value;
//               with negate = result sign it re-applies the sign. Arithmetic
//               is modulo 2^WIDTH, so |-2^(WIDTH-1)| reads as 2^(WIDTH-1)
//               when interpreted unsigned.
// Ports       : value  [WIDTH-1:0] in  - operand
//               negate             in  - 1 = return -value, 0 = pass through
//               result [WIDTH-1:0] out - adjusted value
// Revision    : 1.0 - initial release
// ============================================================================
module div_sign_adj #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule
`default_nettype wire

// File: rtl/div_seq_sr.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_sr
// Description : Multi-cycle radix-2 restoring divider, signed or unsigned per
//               operation, with valid/ready handshakes on input and output.
//               One quotient bit per cycle; a single operation in flight.
// Ports       : clk                          in  - clock, rising edge
//               rstn                         in  - async reset, active low
//               in_valid / in_ready          in/out - request handshake
//               signed_mode                  in  - 1 = two's complement
//               dividend, divisor [DW-1:0]   in  - operands
//               out_valid / out_ready        out/in - result handshake
//               quotient, remainder [DW-1:0] out - result
//               div_by_zero, overflow        out - status flags
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq_sr
  import div_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int CNTW      = $clog2(DATAWIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [DATAWIDTH-1:0] dividend,
  input  logic [DATAWIDTH-1:0] divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] quotient,
  output logic [DATAWIDTH-1:0] remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam logic [DATAWIDTH-1:0] ZERO_QUO = DIV_ZERO_QUO[DATAWIDTH-1:0];
  localparam logic [DATAWIDTH-1:0] SMIN     =
    DATAWIDTH'(DIV_SMIN >> (DIV_MAX_W - DATAWIDTH));
  localparam logic [CNTW-1:0]      CNT_LAST = CNTW'(DATAWIDTH - 1);

  div_state_e state, state_nxt;

  logic [CNTW-1:0]        cnt;
  logic [2*DATAWIDTH-1:0] prem;       // partial remainder : dividend bits
  logic [DATAWIDTH-1:0]   quo_sr;     // quotient shift register
  logic [DATAWIDTH-1:0]   dvs_mag;    // divisor magnitude
  logic                   sgn;
  logic                   q_neg;
  logic                   r_neg;

  logic                   accept;
  logic [DATAWIDTH-1:0]   dvd_mag_in;
  logic [DATAWIDTH-1:0]   dvs_mag_in;
  logic [DATAWIDTH-1:0]   quo_fixed;
  logic [DATAWIDTH-1:0]   rem_fixed;

  // Shifted upper half carried with one extra bit: when the divisor magnitude
  // exceeds 2^(DATAWIDTH-1) the doubled remainder needs DATAWIDTH+1 bits.
  logic [DATAWIDTH:0]     trial;
  logic                   trial_ge;
  logic [DATAWIDTH-1:0]   trial_diff;

  // --------------------------------------------------------------------------
  // Sign handling
  // --------------------------------------------------------------------------
  div_sign_adj #(.WIDTH(DATAWIDTH)) u_dvd_mag (
    .value  (dividend),
    .negate (signed_mode & dividend[DATAWIDTH-1]),
    .result (dvd_mag_in)
  );

  div_sign_adj #(.WIDTH(DATAWIDTH)) u_dvs_mag (
    .value  (divisor),
    .negate (signed_mode & divisor[DATAWIDTH-1]),
    .result (dvs_mag_in)
  );

  div_sign_adj #(.WIDTH(DATAWIDTH)) u_quo_fix (
    .value  (quo_sr),
    .negate (q_neg),
    .result (quo_fixed)
  );

  div_sign_adj #(.WIDTH(DATAWIDTH)) u_rem_fix (
    .value  (prem[2*DATAWIDTH-1:DATAWIDTH]),
    .negate (r_neg),
    .result (rem_fixed)
  );

  // --------------------------------------------------------------------------
  // Restoring step
  // --------------------------------------------------------------------------
  assign trial      = prem[2*DATAWIDTH-1:DATAWIDTH-1];
  assign trial_ge   = (trial >= {1'b0, dvs_mag});
  // Only used when trial >= dvs_mag, where the true difference fits.
  assign trial_diff = trial[DATAWIDTH-1:0] - dvs_mag;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          state_nxt = (divisor == '0) ? ZERO : CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_LAST) begin
          state_nxt = FIX;
        end
      end
      FIX:  state_nxt = DONE;
      ZERO: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt         <= '0;
      prem        <= '0;
      quo_sr      <= '0;
      dvs_mag     <= '0;
      sgn         <= 1'b0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sgn     <= signed_mode;
            q_neg   <= signed_mode & (dividend[DATAWIDTH-1] ^ divisor[DATAWIDTH-1]);
            r_neg   <= signed_mode & dividend[DATAWIDTH-1];
            dvs_mag <= dvs_mag_in;
            quo_sr  <= '0;
            cnt     <= '0;
            // Divide-by-zero returns the raw dividend bits, so keep them
            // unmodified in that case instead of the magnitude.
            prem    <= {{DATAWIDTH{1'b0}},
                        (divisor == '0) ? dividend : dvd_mag_in};
          end
        end
        CALC: begin
          prem   <= {(trial_ge ? trial_diff : trial[DATAWIDTH-1:0]),
                     prem[DATAWIDTH-2:0], 1'b0};
          quo_sr <= {quo_sr[DATAWIDTH-2:0], trial_ge};
          cnt    <= cnt + 1'b1;
        end
        FIX: begin
          quotient    <= quo_fixed;
          remainder   <= rem_fixed;
          div_by_zero <= 1'b0;
          // A non-negative signed quotient with magnitude 2^(N-1) can only
          // come from -2^(N-1) / -1; it is left un-negated as 0x80..0.
          overflow    <= sgn & ~q_neg & (quo_sr == SMIN);
        end
        ZERO: begin
          quotient    <= ZERO_QUO;
          remainder   <= prem[DATAWIDTH-1:0];
          div_by_zero <= 1'b1;
          overflow    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
